adder_accumulate_ctrl: RTL and testbench

- Sequencing and register stage wrapped around the 16-bit carry-select adder.
- Holds accumulator A and operand B, drives them onto the adder inputs, waits a fixed settle interval, then captures Sum/CO back into A and the carry flag.
- Driven by switch inputs and push-button style level commands; one add is performed per Run press.

---
 rtl/adder_accumulate_ctrl.sv | 129 ++++++++++++
 tb/tb_adder_accumulate_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulate_ctrl.sv
// Sequencing and register stage around an external carry-select adder.
// Holds accumulator A and operand B, presents them to the adder, waits a
// fixed settle interval, then captures Sum/CO back into A and the carry flag.
module adder_accumulate_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Sw,
  input  logic             Load_B,
  input  logic             Clear_A,
  input  logic             Run,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  input  logic [WIDTH-1:0] Sum,
  input  logic             CO,
  output logic [WIDTH-1:0] Acc,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       settle_cnt;
  logic [3:0]       settle_cnt_next;
  logic             run_q;
  logic             start;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic             done_reg;

  assign start = Run & ~run_q;

  // State, settle counter and Run edge-detect registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      run_q      <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      run_q      <= Run;
    end
  end

  // Next-state logic: one add per Run rising edge, then park in HOLD until Run drops.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next      = SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_next = CAPTURE;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end
      CAPTURE: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (!Run) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand registers: loads/clears only while idle, result captured in CAPTURE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (Clear_A) begin
          a_reg     <= '0;
          carry_reg <= 1'b0;
        end
        if (Load_B) begin
          b_reg <= Sw;
        end
      end else if (state == CAPTURE) begin
        a_reg     <= Sum;
        carry_reg <= CO;
      end
    end
  end

  // Done is high for exactly the first HOLD cycle, i.e. the cycle after capture.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state == CAPTURE);
    end
  end

  assign Add_A = a_reg;
  assign Add_B = b_reg;
  assign Acc   = a_reg;
  assign Carry = carry_reg;
  assign Busy  = (state == SETTLE) || (state == CAPTURE);
  assign Done  = done_reg;

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Self-checking bench for adder_accumulate_ctrl: a table of load/clear/add
// operations, hand-written multi-cycle corner cases and a randomized phase
// checked against a plain-arithmetic accumulator model.
module tb_adder_accumulate_ctrl;

  localparam int W      = 16;
  localparam int SETTLE = 2;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw;
  logic         load_b;
  logic         clear_a;
  logic         run;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] sum;
  logic         co;
  logic [W-1:0] acc;
  logic         carry;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;

  logic [W-1:0] m_acc;
  logic [W-1:0] m_b;
  logic         m_carry;

  typedef struct {
    logic         clr;
    logic         ld;
    logic [W-1:0] sw_v;
    logic         start;
    logic [W-1:0] exp_acc;
    logic         exp_carry;
    logic [W-1:0] exp_b;
  } vec_t;

  vec_t vecs[11];

  adder_accumulate_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk(clk), .Reset_n(reset_n), .Sw(sw), .Load_B(load_b), .Clear_A(clear_a),
    .Run(run), .Add_A(add_a), .Add_B(add_b), .Sum(sum), .CO(co),
    .Acc(acc), .Carry(carry), .Busy(busy), .Done(done)
  );

  // External adder the controller sequences.
  assign {co, sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic ld, input logic [W-1:0] sw_v, input logic r);
    clear_a = clr;
    load_b  = ld;
    sw      = sw_v;
    run     = r;
  endtask

  // Reference: load/clear happen first, then the add uses the new values.
  task automatic modelOp(input logic clr, input logic ld, input logic [W-1:0] sw_v, input logic start);
    logic [W:0] wide;
    if (clr) begin
      m_acc   = '0;
      m_carry = 1'b0;
    end
    if (ld) m_b = sw_v;
    if (start) begin
      wide    = {1'b0, m_acc} + {1'b0, m_b};
      m_acc   = wide[W-1:0];
      m_carry = wide[W];
    end
  endtask

  // Performs one IDLE-cycle operation, optionally with a Run rising edge, and
  // checks Busy/Done timing. Leaves the DUT in IDLE with Run low.
  task automatic runOp(input logic clr, input logic ld, input logic [W-1:0] sw_v, input logic start);
    int k;
    logic got;
    applyStimulus(clr, ld, sw_v, start);
    step();
    applyStimulus(1'b0, 1'b0, sw_v, start);
    if (start) begin
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      got = 1'b0;
      k   = 0;
      for (int i = 1; i <= 40; i++) begin
        step();
        if (done) begin
          got = 1'b1;
          k   = i;
          break;
        end
      end
      if (!got) begin
        checkOutput("done_timeout", 32'd0, 32'd1);
      end else begin
        checkOutput("done_latency", 32'(k), 32'(SETTLE + 1));
        checkOutput("busy_with_done", 32'(busy), 32'd0);
      end
      run = 1'b0;
      step();
      checkOutput("done_single_cycle", 32'(done), 32'd0);
      step();
    end
  endtask

  initial begin
    int n_done;
    int overlap;
    int b_changed;
    logic got;
    logic clr_r;
    logic ld_r;
    logic st_r;
    logic [W-1:0] sw_r;

    n_checks = 0;
    n_fail   = 0;
    m_acc    = '0;
    m_b      = '0;
    m_carry  = 1'b0;

    //             clr   ld    sw        start exp_acc   c     exp_b
    vecs[0]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFFF};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFF};
    vecs[3]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b0, 16'h0001};
    vecs[4]  = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'hFFFF};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[6]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0002, 1'b0, 16'h0002};
    vecs[7]  = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0000, 1'b1, 16'hFFFE};
    vecs[8]  = '{1'b0, 1'b1, 16'h8000, 1'b1, 16'h8000, 1'b0, 16'h8000};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8000};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h8000};

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    step();
    checkOutput("reset_acc", 32'(acc), 32'd0);
    checkOutput("reset_add_b", 32'(add_b), 32'd0);
    checkOutput("reset_carry", 32'(carry), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      runOp(vecs[i].clr, vecs[i].ld, vecs[i].sw_v, vecs[i].start);
      modelOp(vecs[i].clr, vecs[i].ld, vecs[i].sw_v, vecs[i].start);
      checkOutput($sformatf("vec%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
      checkOutput($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      checkOutput($sformatf("vec%0d_b", i), 32'(add_b), 32'(vecs[i].exp_b));
    end

    $display("[TB] held Run gives one add");
    runOp(1'b1, 1'b1, 16'h0003, 1'b1);
    runOp(1'b0, 1'b1, 16'hFFFF, 1'b0);
    run     = 1'b1;
    n_done  = 0;
    overlap = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) n_done++;
      if (done && busy) overlap++;
    end
    run = 1'b0;
    step();
    step();
    checkOutput("held_done_count", 32'(n_done), 32'd1);
    checkOutput("held_overlap", 32'(overlap), 32'd0);
    checkOutput("held_acc", 32'(acc), 32'h0002);
    checkOutput("held_carry", 32'(carry), 32'd1);
    m_acc   = 16'h0002;
    m_b     = 16'hFFFF;
    m_carry = 1'b1;

    $display("[TB] load/clear ignored while busy");
    run = 1'b1;
    step();
    applyStimulus(1'b1, 1'b1, 16'hF0FF, 1'b1);
    got       = 1'b0;
    b_changed = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (add_b !== 16'hFFFF) b_changed++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("busy_load_done_seen", 32'(got), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    step();
    checkOutput("busy_load_b_stable", 32'(b_changed), 32'd0);
    checkOutput("busy_load_acc", 32'(acc), 32'h0001);
    checkOutput("busy_load_carry", 32'(carry), 32'd1);
    checkOutput("busy_load_b", 32'(add_b), 32'hFFFF);

    $display("[TB] reset during settle");
    runOp(1'b1, 1'b1, 16'h1234, 1'b1);
    checkOutput("pre_reset_acc", 32'(acc), 32'h1234);
    run = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_acc", 32'(acc), 32'd0);
    checkOutput("async_reset_carry", 32'(carry), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_b", 32'(add_b), 32'd0);
    run = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    n_done  = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    checkOutput("post_reset_no_done", 32'(n_done), 32'd0);
    checkOutput("post_reset_acc", 32'(acc), 32'd0);
    m_acc   = '0;
    m_b     = '0;
    m_carry = 1'b0;

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      clr_r = ($urandom_range(0, 3) == 0);
      ld_r  = ($urandom_range(0, 1) == 1);
      st_r  = ($urandom_range(0, 3) != 0);
      sw_r  = W'($urandom);
      runOp(clr_r, ld_r, sw_r, st_r);
      modelOp(clr_r, ld_r, sw_r, st_r);
      checkOutput($sformatf("rnd%0d_acc", i), 32'(acc), 32'(m_acc));
      checkOutput($sformatf("rnd%0d_carry", i), 32'(carry), 32'(m_carry));
      checkOutput($sformatf("rnd%0d_b", i), 32'(add_b), 32'(m_b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
